// File: rtl/load_store_pkg.sv
// Shared state and mode encodings for the multi-channel fill/drain level counters.
package load_store_pkg;

  typedef enum logic [1:0] {FILL, HOLD, DRAIN} ls_state_t;

  localparam logic LS_TRI = 1'b0;
  localparam logic LS_SAW = 1'b1;

endpackage

// File: rtl/load_store_chan.sv
// One fill/drain channel: ramps vol between LO and HI, dwells at HI, then drains or reloads.
module load_store_chan
  import load_store_pkg::*;
#(
  parameter int CBITS    = 15,
  parameter int HI       = 25000,
  parameter int LO       = 0,
  parameter int STEP     = 1,
  parameter int HOLD_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  output logic             sig,
  output logic             filling,
  output logic [CBITS-1:0] vol
);

  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  ls_state_t         state;
  logic [HW-1:0]     hcnt;
  logic [CBITS-1:0]  vol_up;
  logic [CBITS-1:0]  vol_dn;

  // One guard bit above CBITS so vol+STEP can never wrap before the clamp.
  function automatic logic [CBITS-1:0] sat_up(input logic [CBITS-1:0] v);
    logic [CBITS:0] s;
    s = {1'b0, v} + (CBITS+1)'(STEP);
    return (s >= (CBITS+1)'(HI)) ? CBITS'(HI) : s[CBITS-1:0];
  endfunction

  function automatic logic [CBITS-1:0] sat_dn(input logic [CBITS-1:0] v);
    logic signed [CBITS+1:0] d;
    d = $signed({2'b00, v}) - $signed((CBITS+2)'(STEP));
    return (d <= $signed((CBITS+2)'(LO))) ? CBITS'(LO) : d[CBITS-1:0];
  endfunction

  assign vol_up = sat_up(vol);
  assign vol_dn = sat_dn(vol);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      vol   <= CBITS'(LO);
      hcnt  <= '0;
    end else if (en) begin
      case (state)
        FILL: begin
          vol <= vol_up;
          if (vol_up == CBITS'(HI)) begin
            state <= HOLD;
            hcnt  <= '0;
          end
        end
        HOLD: begin
          if (hcnt < HW'(HOLD_CYC)) begin
            hcnt <= hcnt + HW'(1);
          end else if (mode == LS_SAW) begin
            state <= FILL;
            vol   <= CBITS'(LO);
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          vol <= vol_dn;
          if (vol_dn == CBITS'(LO)) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  assign sig     = (state == HOLD);
  assign filling = (state == FILL);

endmodule

// File: rtl/load_store_multi.sv
// NCH independent fill/drain channels with aggregate any/all dwell flags.
module load_store_multi
  import load_store_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CBITS    = 15,
  parameter int HI       = 25000,
  parameter int LO       = 0,
  parameter int STEP     = 1,
  parameter int HOLD_CYC = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       mode,
  output logic [NCH-1:0]       sig,
  output logic [NCH-1:0]       filling,
  output logic [NCH*CBITS-1:0] vol,
  output logic                 any_sig,
  output logic                 all_sig
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    load_store_chan #(
      .CBITS   (CBITS),
      .HI      (HI),
      .LO      (LO),
      .STEP    (STEP),
      .HOLD_CYC(HOLD_CYC)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[i]),
      .mode   (mode[i]),
      .sig    (sig[i]),
      .filling(filling[i]),
      .vol    (vol[i*CBITS +: CBITS])
    );
  end

  assign any_sig = |sig;
  assign all_sig = &sig;

endmodule

// File: tb/tb_load_store_multi.sv
// Directed bench for load_store_multi: vector table on the STEP=3 build, plus dwell and full-step builds.
module tb_load_store_multi;

  logic       clk;
  logic       rst_n;
  logic [1:0] en_a, mode_a, en_b, mode_b, en_c, mode_c;

  logic [1:0] sig_a, fil_a, sig_b, fil_b, sig_c, fil_c;
  logic [9:0] vol_a, vol_b, vol_c;
  logic       any_a, all_a, any_b, all_b, any_c, all_c;

  int vectors;
  int miscompares;

  load_store_multi #(.NCH(2), .CBITS(5), .HI(10), .LO(0), .STEP(3), .HOLD_CYC(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sig(sig_a), .filling(fil_a),
    .vol(vol_a), .any_sig(any_a), .all_sig(all_a));

  load_store_multi #(.NCH(2), .CBITS(5), .HI(10), .LO(0), .STEP(3), .HOLD_CYC(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sig(sig_b), .filling(fil_b),
    .vol(vol_b), .any_sig(any_b), .all_sig(all_b));

  load_store_multi #(.NCH(2), .CBITS(5), .HI(10), .LO(0), .STEP(10), .HOLD_CYC(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode_c), .sig(sig_c), .filling(fil_c),
    .vol(vol_c), .any_sig(any_c), .all_sig(all_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [1:0] en;
    logic [1:0] mode;
    logic [4:0] v0;
    logic [4:0] v1;
    logic [1:0] sig;
    logic [1:0] fil;
    logic       any;
    logic       all;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] e, input logic [1:0] m,
                     input int v0, input int v1, input logic [1:0] s, input logic [1:0] f,
                     input logic an, input logic al);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.v0 = 5'(v0); v.v1 = 5'(v1);
    v.sig = s; v.fil = f; v.any = an; v.all = al;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Invariants on every build: vol within [LO,HI], sig implies vol==HI, sig/filling exclusive.
  task automatic inv(input string name, input logic [9:0] v, input logic [1:0] s, input logic [1:0] f);
    for (int i = 0; i < 2; i++) begin
      if (v[i*5 +: 5] > 5'd10 || (s[i] && v[i*5 +: 5] != 5'd10) || (s[i] && f[i])) begin
        miscompares++;
        $display("FAIL inv_%s ch%0d: vol=%0d sig=%0b filling=%0b", name, i, v[i*5 +: 5], s[i], f[i]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      inv("a", vol_a, sig_a, fil_a);
      inv("b", vol_b, sig_b, fil_b);
      inv("c", vol_c, sig_c, fil_c);
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en_a = 2'b00; mode_a = 2'b00;
    en_b = 2'b00; mode_b = 2'b00;
    en_c = 2'b00; mode_c = 2'b00;

    // Triangle ramp on both channels
    add(0, 2'b11, 2'b00,  0,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  3,  3, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  6,  6, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  9,  9, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00, 10, 10, 2'b11, 2'b00, 1, 1);
    add(1, 2'b11, 2'b00, 10, 10, 2'b00, 2'b00, 0, 0);
    add(1, 2'b11, 2'b00,  7,  7, 2'b00, 2'b00, 0, 0);
    add(1, 2'b11, 2'b00,  4,  4, 2'b00, 2'b00, 0, 0);
    add(1, 2'b11, 2'b00,  1,  1, 2'b00, 2'b00, 0, 0);
    add(1, 2'b11, 2'b00,  0,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  3,  3, 2'b00, 2'b11, 0, 0);
    // ch1 sawtooth, ch0 triangle
    add(0, 2'b11, 2'b10,  0,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b10,  3,  3, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b10,  6,  6, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b10,  9,  9, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b10, 10, 10, 2'b11, 2'b00, 1, 1);
    add(1, 2'b11, 2'b10, 10,  0, 2'b00, 2'b10, 0, 0);
    add(1, 2'b11, 2'b10,  7,  3, 2'b00, 2'b10, 0, 0);
    // en0 toggled 1,0,0,1 with ch1 disabled
    add(0, 2'b00, 2'b00,  0,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b01, 2'b00,  3,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b00, 2'b00,  3,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b00, 2'b00,  3,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b01, 2'b00,  6,  0, 2'b00, 2'b11, 0, 0);
    // Reset mid-drain, then ramp resumes
    add(0, 2'b11, 2'b00,  0,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  3,  3, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  6,  6, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  9,  9, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00, 10, 10, 2'b11, 2'b00, 1, 1);
    add(1, 2'b11, 2'b00, 10, 10, 2'b00, 2'b00, 0, 0);
    add(1, 2'b11, 2'b00,  7,  7, 2'b00, 2'b00, 0, 0);
    add(0, 2'b11, 2'b00,  0,  0, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  3,  3, 2'b00, 2'b11, 0, 0);
    add(1, 2'b11, 2'b00,  6,  6, 2'b00, 2'b11, 0, 0);

    foreach (tbl[k]) begin
      rst_n = tbl[k].rst_n; en_a = tbl[k].en; mode_a = tbl[k].mode;
      step();
      chk($sformatf("vec%0d", k),
          {6'd0, vol_a[4:0], vol_a[9:5], sig_a, fil_a, any_a, all_a, 10'd0},
          {6'd0, tbl[k].v0, tbl[k].v1, tbl[k].sig, tbl[k].fil, tbl[k].any, tbl[k].all, 10'd0});
    end

    // Dwell of HOLD_CYC=2: sig0 high after edges 4..6 only, ch1 idle at LO
    rst_n = 1'b0; en_a = 2'b00;
    step();
    rst_n = 1'b1; en_b = 2'b01; mode_b = 2'b00;
    for (int e = 1; e <= 9; e++) begin
      step();
      chk($sformatf("hold_sig0_e%0d", e), {31'd0, sig_b[0]}, {31'd0, (e >= 4 && e <= 6)});
      chk($sformatf("hold_ch1_e%0d", e), {26'd0, vol_b[9:5], fil_b[1]}, {26'd0, 5'd0, 1'b1});
    end
    chk("hold_vol0_e9", {27'd0, vol_b[4:0]}, 32'd4);

    // STEP equal to HI-LO: single-step fill and drain
    rst_n = 1'b0; en_b = 2'b00;
    step();
    chk("full_rst", {22'd0, vol_c, sig_c, fil_c}, {22'd0, 10'd0, 2'b00, 2'b11});
    rst_n = 1'b1; en_c = 2'b11; mode_c = 2'b00;
    step();
    chk("full_e1", {22'd0, vol_c, sig_c, fil_c, all_c, any_c}, {20'd0, 5'd10, 5'd10, 2'b11, 2'b00, 1'b1, 1'b1});
    step();
    chk("full_e2", {22'd0, vol_c, sig_c, fil_c}, {22'd0, 5'd10, 5'd10, 2'b00, 2'b00});
    step();
    chk("full_e3", {22'd0, vol_c, sig_c, fil_c}, {22'd0, 5'd0, 5'd0, 2'b00, 2'b11});
    step();
    chk("full_e4", {22'd0, vol_c, sig_c, fil_c}, {22'd0, 5'd10, 5'd10, 2'b11, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
